// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle for the multiply/divide unit.
//   start, op[1:0]     operation request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   srcA, srcB         operands (multiplicand/dividend, multiplier/divisor)
//   writeHi, writeLo   MTHI/MTLO strobes, data on writeData
//   hi, lo             HI/LO registers
//   busy, done         operation in progress / one-cycle result pulse
// master: the requester (pipeline or bench); slave: mult_div_unit.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        writeHi;
  logic        writeLo;
  logic [31:0] writeData;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (
    output start, op, srcA, srcB, writeHi, writeLo, writeData,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, srcA, srcB, writeHi, writeLo, writeData,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide unit with HI/LO registers.
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  mult_div_unit_if.slave: start/op/srcA/srcB request, writeHi/writeLo/
//        writeData MTHI/MTLO, hi/lo/busy/done results
// Multiply: radix-2 shift-add on magnitudes, 32 cycles, then sign fix.
// Divide:   restoring division on magnitudes, 32 cycles, then sign fix.
// Result is committed to hi/lo 34 edges after the accepting edge.
// Configuration macro MULT_DIV_UNIT_DIV_EN: when defined the divider is built;
// when undefined DIV/DIVU requests are ignored.
module mult_div_unit (
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMul  = 3'd1,
`ifdef MULT_DIV_UNIT_DIV_EN
    StDiv  = 3'd2,
`endif
    StFix  = 3'd3,
    StDone = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] mag_b_q, mag_b_d;
  // Working register: {acc, multiplier} for multiply, {rem, quotient} for divide.
  logic [63:0] prod_q, prod_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
`ifdef MULT_DIV_UNIT_DIV_EN
  logic        is_div_q, is_div_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
`endif

  logic        start_ok;
  logic        op_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;

  assign op_signed = ~bus.op[0];
  assign mag_a     = (op_signed && bus.srcA[31]) ? (32'd0 - bus.srcA) : bus.srcA;
  assign mag_b     = (op_signed && bus.srcB[31]) ? (32'd0 - bus.srcB) : bus.srcB;

`ifdef MULT_DIV_UNIT_DIV_EN
  assign start_ok = bus.start;
`else
  assign start_ok = bus.start & ~bus.op[1];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    mag_b_d  = mag_b_q;
    prod_d   = prod_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    mul_sum  = '0;
`ifdef MULT_DIV_UNIT_DIV_EN
    is_div_d  = is_div_q;
    a_raw_d   = a_raw_q;
    div_shift = '0;
    div_diff  = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          sign_a_d = op_signed & bus.srcA[31];
          sign_b_d = op_signed & bus.srcB[31];
          mag_b_d  = mag_b;
          prod_d   = {32'd0, mag_a};
          cnt_d    = '0;
`ifdef MULT_DIV_UNIT_DIV_EN
          is_div_d = bus.op[1];
          a_raw_d  = bus.srcA;
          state_d  = bus.op[1] ? StDiv : StMul;
`else
          state_d  = StMul;
`endif
        end else if (!bus.start) begin
          // MTHI/MTLO only land when no request is being made this cycle.
          if (bus.writeHi) hi_d = bus.writeData;
          if (bus.writeLo) lo_d = bus.writeData;
        end
      end

      StMul: begin
        mul_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mag_b_q} : 33'd0);
        prod_d  = {mul_sum, prod_q[31:1]};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFix;
      end

`ifdef MULT_DIV_UNIT_DIV_EN
      StDiv: begin
        // Remainder stays below the divisor, so 33 bits cover shift and subtract.
        div_shift = {prod_q[63:32], prod_q[31]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        prod_d    = {(div_diff[32] ? div_shift[31:0] : div_diff[31:0]),
                     prod_q[30:0], ~div_diff[32]};
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFix;
      end
`endif

      StFix: begin
        prod_d  = (sign_a_q ^ sign_b_q) ? (64'd0 - prod_q) : prod_q;
`ifdef MULT_DIV_UNIT_DIV_EN
        if (is_div_q) begin
          if (mag_b_q == 32'd0) begin
            prod_d = {a_raw_q, 32'hFFFF_FFFF};
          end else begin
            // Quotient truncates toward zero; remainder follows the dividend.
            prod_d[31:0]  = (sign_a_q ^ sign_b_q) ? (32'd0 - prod_q[31:0]) : prod_q[31:0];
            prod_d[63:32] = sign_a_q ? (32'd0 - prod_q[63:32]) : prod_q[63:32];
          end
        end
`endif
        state_d = StDone;
      end

      StDone: begin
        hi_d    = prod_q[63:32];
        lo_d    = prod_q[31:0];
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_b_q  <= '0;
      prod_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
      is_div_q <= 1'b0;
      a_raw_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_b_q  <= mag_b_d;
      prod_q   <= prod_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MULT_DIV_UNIT_DIV_EN
      is_div_q <= is_div_d;
      a_raw_q  <= a_raw_d;
`endif
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven, hand-sequenced and randomized checks of
// mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if bus_if ();

  mult_div_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.start     = 1'b0;
    bus_if.op        = 2'b00;
    bus_if.srcA      = '0;
    bus_if.srcB      = '0;
    bus_if.writeHi   = 1'b0;
    bus_if.writeLo   = 1'b0;
    bus_if.writeData = '0;
  endtask

  // Reference: plain arithmetic on the architectural definitions.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    sa = a;
    sb = b;
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        {eh, el} = sp;
      end
      2'b01: begin
        up = {32'd0, a} * {32'd0, b};
        {eh, el} = up;
      end
      2'b10: begin
        if (b == 0) begin
          eh = a; el = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          eh = 0; el = 32'h8000_0000;
        end else begin
          el = sa / sb; eh = sa % sb;
        end
      end
      default: begin
        if (b == 0) begin
          eh = a; el = 32'hFFFF_FFFF;
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endtask

  // Issue one operation and follow it to completion. Operand/op inputs are
  // scrambled while busy; with poke set, a second start plus MTHI/MTLO strobes
  // are presented on the fifth busy cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input bit poke,
                        input string nm);
    logic [31:0] hi0;
    logic [31:0] lo0;
    int          lat;
    int          dones;
    bit          busy_bad;
    bit          hold_bad;
    hi0      = bus_if.hi;
    lo0      = bus_if.lo;
    lat      = -1;
    dones    = 0;
    busy_bad = 1'b0;
    hold_bad = 1'b0;
    bus_if.op      = o;
    bus_if.srcA    = a;
    bus_if.srcB    = b;
    bus_if.writeHi = 1'b0;
    bus_if.writeLo = 1'b0;
    bus_if.start   = 1'b1;
    @(posedge clk); #1;
    if (bus_if.busy !== 1'b1) busy_bad = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      bus_if.start     = poke && (k == 5);
      bus_if.writeHi   = poke && (k == 5);
      bus_if.writeLo   = poke && (k == 5);
      bus_if.writeData = 32'h1234;
      bus_if.op        = 2'($urandom);
      bus_if.srcA      = $urandom;
      bus_if.srcB      = $urandom;
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) begin
        dones++;
        lat = k;
        break;
      end
      if (bus_if.busy !== 1'b1) busy_bad = 1'b1;
      if (bus_if.hi !== hi0 || bus_if.lo !== lo0) hold_bad = 1'b1;
    end
    idle_inputs();
    chk({nm, " latency"}, 64'(lat), 64'd34);
    chk({nm, " busy during op"}, 64'(busy_bad), 64'd0);
    chk({nm, " hi/lo hold"}, 64'(hold_bad), 64'd0);
    chk({nm, " hi"}, 64'(bus_if.hi), 64'(eh));
    chk({nm, " lo"}, 64'(bus_if.lo), 64'(el));
    chk({nm, " busy at done"}, 64'(bus_if.busy), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) dones++;
    end
    chk({nm, " done pulses"}, 64'(dones), 64'd1);
  endtask

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_h;
  logic [31:0] r_l;
  logic [1:0]  r_op;
  logic [31:0] lo_pre;
  logic [31:0] hi_pre;
  int          lat2;
  bit          seen_busy;
  bit          seen_done;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    #2 rst = 1'b1;
    #2;
    chk("reset hi", 64'(bus_if.hi), 64'd0);
    chk("reset lo", 64'(bus_if.lo), 64'd0);
    chk("reset busy", 64'(bus_if.busy), 64'd0);
    chk("reset done", 64'(bus_if.done), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
    vecs.push_back('{2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006});
    vecs.push_back('{2'b00, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000});
`ifdef MULT_DIV_UNIT_DIV_EN
    vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF});
    vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vecs.push_back('{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF});
    vecs.push_back('{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF});
`endif
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0,
             $sformatf("vec%0d", i));
    end

    // Second start and MTHI/MTLO while busy must not disturb anything.
    run_op(2'b01, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'h0000_0000, 1'b1, "poke");

    // MTHI in IDLE: visible on the next edge, LO untouched, no done.
    lo_pre = bus_if.lo;
    bus_if.writeHi   = 1'b1;
    bus_if.writeData = 32'h1234;
    @(posedge clk); #1;
    idle_inputs();
    chk("mthi hi", 64'(bus_if.hi), 64'h1234);
    chk("mthi lo", 64'(bus_if.lo), 64'(lo_pre));
    chk("mthi done", 64'(bus_if.done), 64'd0);

    // MTLO together with start: the write is dropped, the multiply runs.
    lo_pre = bus_if.lo;
    bus_if.op        = 2'b01;
    bus_if.srcA      = 32'd2;
    bus_if.srcB      = 32'd3;
    bus_if.start     = 1'b1;
    bus_if.writeLo   = 1'b1;
    bus_if.writeData = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    idle_inputs();
    chk("mtlo+start lo", 64'(bus_if.lo), 64'(lo_pre));
    chk("mtlo+start busy", 64'(bus_if.busy), 64'd1);
    lat2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) begin
        lat2 = k;
        break;
      end
    end
    chk("mtlo+start latency", 64'(lat2), 64'd34);
    chk("mtlo+start result", {bus_if.hi, bus_if.lo}, 64'd6);

    // Reset in the middle of an operation.
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080, 1'b0, "pre-rst");
`ifdef MULT_DIV_UNIT_DIV_EN
    bus_if.op = 2'b10;
`else
    bus_if.op = 2'b01;
`endif
    bus_if.srcA  = 32'd1000;
    bus_if.srcB  = 32'd7;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst busy", 64'(bus_if.busy), 64'd0);
    chk("midrst done", 64'(bus_if.done), 64'd0);
    chk("midrst hi", 64'(bus_if.hi), 64'd0);
    chk("midrst lo", 64'(bus_if.lo), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    seen_busy = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus_if.busy === 1'b1) seen_busy = 1'b1;
      if (bus_if.done === 1'b1) seen_done = 1'b1;
    end
    chk("after rst busy", 64'(seen_busy), 64'd0);
    chk("after rst done", 64'(seen_done), 64'd0);
    run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, "post-rst");

`ifndef MULT_DIV_UNIT_DIV_EN
    // Without the divider, DIV/DIVU requests are ignored.
    for (int d = 2; d <= 3; d++) begin
      hi_pre = bus_if.hi;
      lo_pre = bus_if.lo;
      bus_if.op    = 2'(d);
      bus_if.srcA  = 32'd100;
      bus_if.srcB  = 32'd7;
      bus_if.start = 1'b1;
      @(posedge clk); #1;
      idle_inputs();
      seen_busy = bus_if.busy;
      seen_done = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (bus_if.busy === 1'b1) seen_busy = 1'b1;
        if (bus_if.done === 1'b1) seen_done = 1'b1;
      end
      chk($sformatf("nodiv%0d busy", d), 64'(seen_busy), 64'd0);
      chk($sformatf("nodiv%0d done", d), 64'(seen_done), 64'd0);
      chk($sformatf("nodiv%0d hilo", d), {bus_if.hi, bus_if.lo}, {hi_pre, lo_pre});
    end
`endif

    // Randomized operations against the reference model.
    for (int n = 0; n < 30; n++) begin
`ifdef MULT_DIV_UNIT_DIV_EN
      r_op = 2'($urandom_range(0, 3));
`else
      r_op = 2'($urandom_range(0, 1));
`endif
      r_a = $urandom;
      r_b = $urandom;
      if ($urandom_range(0, 3) == 0) r_b = $urandom_range(0, 20);
      if ($urandom_range(0, 7) == 0) r_b = 32'd0;
      if ($urandom_range(0, 3) == 0) r_b = -r_b;
      model(r_op, r_a, r_b, r_h, r_l);
      run_op(r_op, r_a, r_b, r_h, r_l, 1'b0, $sformatf("rand%0d op%0d", n, r_op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin the operation selected by op, using srcA/srcB.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 srcA  input  32  first operand (register-file data1): multiplicand or dividend.
REQ-007 srcB  input  32  second operand (register-file data2): multiplier or divisor.
REQ-008 writeHi  input  1  MTHI strobe: load writeData into HI.
REQ-009 writeLo  input  1  MTLO strobe: load writeData into LO.
REQ-010 writeData  input  32  data for MTHI/MTLO.
REQ-011 hi  output  32  HI register (MFHI source).
REQ-012 lo  output  32  LO register (MFLO source).
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  one-cycle pulse when hi/lo take a new result.

Function
REQ-015 The FSM SHALL have the states IDLE, MUL, DIV, FIX and DONE.
REQ-016 IDLE: start=1 SHALL latch op, srcA and srcB, clear the iteration counter, set busy, and enter MUL (op[1]=0) or DIV (op[1]=1).
REQ-017 MUL: radix-2 shift-add, unsigned magnitudes, one bit per cycle, exactly 32 cycles, then FIX.
REQ-018 DIV: restoring division, unsigned magnitudes, one quotient bit per cycle, exactly 32 cycles, then FIX.
REQ-019 FIX (1 cycle): apply sign correction for MULT/DIV; then DONE.
REQ-020 DONE (1 cycle): hi/lo SHALL load the result, done=1, busy=0; then IDLE.
REQ-021 Latency: if start is sampled at edge E0, hi/lo update and done rises at edge E0+34; busy is high from E0 through E0+33.
REQ-022 MULT/MULTU: {hi,lo} SHALL be the full 64-bit product (signed for MULT, unsigned for MULTU).
REQ-023 DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-024 DIVU: lo = unsigned quotient; hi = unsigned remainder.
REQ-025 Divide by zero (DIV or DIVU): lo=32'hFFFFFFFF, hi=srcA, with the normal 34-cycle latency.
REQ-026 DIV of 32'h80000000 by 32'hFFFFFFFF: lo=32'h80000000, hi=0.
REQ-027 start while busy or in DONE SHALL be ignored; latched operands SHALL be unaffected by input changes after E0.
REQ-028 writeHi/writeLo SHALL take effect at the next edge only in IDLE with start=0; they SHALL be ignored otherwise.
REQ-029 start and writeHi/writeLo in the same IDLE cycle: start SHALL win and the writes SHALL be dropped.
REQ-030 hi/lo SHALL hold their values between updates; intermediate iteration state SHALL never appear on hi/lo.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, hi=0, lo=0, busy=0, done=0 and counter=0, independent of clk.
REQ-032 rst asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-033 Macro MULT_DIV_UNIT_DIV_EN defined: the divider and the DIV state SHALL be built, and behaviour SHALL be as above.
REQ-034 Macro undefined: no divider logic SHALL be built; start with op[1]=1 SHALL be ignored (no busy, no done, hi/lo unchanged); MULT/MULTU SHALL be unaffected.

Verification
REQ-035 MULTU with srcA=srcB=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001, done exactly 34 cycles after start.
REQ-036 MULT -3 x 5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1; operands changed during busy -> same result.
REQ-037 DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100 / 0 -> lo=32'hFFFFFFFF, hi=32'h00000064 (DIV_EN defined).
REQ-038 Second start at cycle 5 of a MULTU -> ignored, exactly one done pulse; writeHi=1 with 32'h1234 during busy -> hi unaffected.
REQ-039 IDLE writeHi=1, writeData=32'h1234 -> hi=32'h1234 next edge, lo unchanged, no done; writeLo plus start in the same cycle -> write dropped, operation runs.
REQ-040 rst pulsed 10 cycles into a DIV -> busy=0, hi=lo=0 immediately, no done; a following MULTU 2 x 3 -> lo=6, hi=0 at +34.
